// File: rtl/mmio_gpio_responder_if.sv
// Request/response bus between the CPU data port and a memory-mapped target.
// Ports (modport slave = target side):
//   req_valid/req_ready      request handshake
//   req_we/req_addr          store flag and byte address
//   req_wdata/req_wstrb      store data and byte enables
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata/rsp_err        load data and error flag
interface mmio_gpio_responder_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12
) ();
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mmio_gpio_responder.sv
// Memory-mapped GPIO target on the CPU data bus: drives led[3:0], exposes
// synchronised sw[3:0], debounced btn[3:0] and sticky btn rising-edge flags.
// Ports:
//   clk, n_rst   clock, asynchronous active-low reset
//   bus          mmio_gpio_responder_if.slave request/response bus
//   btn, sw      raw asynchronous button / switch inputs
//   led          registered LED drive
module mmio_gpio_responder #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DEBOUNCE = 15
) (
  input  logic                   clk,
  input  logic                   n_rst,
  mmio_gpio_responder_if.slave   bus,
  input  logic [3:0]             btn,
  input  logic [3:0]             sw,
  output logic [3:0]             led
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE - 1);
  localparam logic [ADDR_W-1:0] ADDR_LED  = ADDR_W'(32'h000);
  localparam logic [ADDR_W-1:0] ADDR_SW   = ADDR_W'(32'h004);
  localparam logic [ADDR_W-1:0] ADDR_BTN  = ADDR_W'(32'h008);
  localparam logic [ADDR_W-1:0] ADDR_EDGE = ADDR_W'(32'h00C);
  localparam logic [ADDR_W-1:0] ADDR_ID   = ADDR_W'(32'h010);
  localparam logic [DATA_W-1:0] ID_VALUE  = DATA_W'(32'h4750_494F);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

  state_e            state_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic [3:0]        led_q;

  logic [3:0]            sw_meta_q, sw_sync_q;
  logic [3:0]            btn_meta_q, btn_sync_q;
  logic [3:0]            btn_deb_q, btn_deb_d;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]            edge_q, edge_d;

  logic              accept_c;
  logic              sel_led_c, sel_sw_c, sel_btn_c, sel_edge_c, sel_id_c, hit_c;
  logic              wr_led_c;
  logic [3:0]        edge_clr_c;
  logic [DATA_W-1:0] rd_val_c;

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign led           = led_q;

  // Register constants are word aligned, so a full-address match also rejects misaligned accesses.
  always_comb begin
    accept_c   = (state_q == IDLE) && bus.req_valid;
    sel_led_c  = (bus.req_addr == ADDR_LED);
    sel_sw_c   = (bus.req_addr == ADDR_SW);
    sel_btn_c  = (bus.req_addr == ADDR_BTN);
    sel_edge_c = (bus.req_addr == ADDR_EDGE);
    sel_id_c   = (bus.req_addr == ADDR_ID);
    hit_c      = sel_led_c | sel_sw_c | sel_btn_c | sel_edge_c | sel_id_c;
    wr_led_c   = accept_c && bus.req_we && sel_led_c && bus.req_wstrb[0];
    edge_clr_c = (accept_c && bus.req_we && sel_edge_c && bus.req_wstrb[0])
                 ? bus.req_wdata[3:0] : 4'b0000;
  end

  // Read mux over current register values.
  always_comb begin
    rd_val_c = '0;
    if (sel_led_c)       rd_val_c[3:0] = led_q;
    else if (sel_sw_c)   rd_val_c[3:0] = sw_sync_q;
    else if (sel_btn_c)  rd_val_c[3:0] = btn_deb_q;
    else if (sel_edge_c) rd_val_c[3:0] = edge_q;
    else if (sel_id_c)   rd_val_c      = ID_VALUE;
  end

  // Per-bit debounce: count consecutive disagreeing cycles, flip on the DEBOUNCE-th one.
  always_comb begin
    btn_deb_d = btn_deb_q;
    cnt_d     = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (btn_sync_q[i] == btn_deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        btn_deb_d[i] = ~btn_deb_q[i];
        cnt_d[i]     = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Sticky rising-edge flags; a new edge overrides a simultaneous clear.
  always_comb begin
    edge_d = (edge_q & ~edge_clr_c) | (btn_deb_d & ~btn_deb_q);
  end

  // Input synchronisers, debounce and edge state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      btn_deb_q  <= '0;
      cnt_q      <= '0;
      edge_q     <= '0;
    end else begin
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= btn;
      btn_sync_q <= btn_meta_q;
      btn_deb_q  <= btn_deb_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
    end
  end

  // Bus FSM: accept in IDLE, hold the registered response in RESP until taken.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      led_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            state_q     <= RESP;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ~hit_c;
            rsp_rdata_q <= (!bus.req_we && hit_c) ? rd_val_c : '0;
            if (wr_led_c) led_q <= bus.req_wdata[3:0];
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Store data and strobe bits that no register consumes.
  logic unused_bits;
  assign unused_bits = ^{bus.req_wdata[DATA_W-1:4], bus.req_wstrb[STRB_W-1:1]};

endmodule
